// File: rtl/hififo_tpc_dma_if.sv
// Descriptor, source-FIFO and PCIe write-request signals of the to-PC DMA engine.
// master = DMA engine side, slave = surrounding logic (descriptor source, FIFO, TX arbiter).
interface hififo_tpc_dma_if #(
    parameter int unsigned COUNT_BITS = 20,
    parameter int unsigned LEVEL_BITS = 10
);
    logic                  desc_valid;
    logic                  desc_ready;
    logic [60:0]           desc_addr;
    logic [COUNT_BITS-1:0] desc_count;

    logic [63:0]           src_data;
    logic [LEVEL_BITS-1:0] src_level;
    logic                  src_read;

    logic                  wr_valid;
    logic                  wr_ready;
    logic [63:0]           wr_addr;
    logic [5:0]            wr_count;
    logic [63:0]           wr_data;
    logic                  wr_last;

    modport master (
        input  desc_valid, desc_addr, desc_count,
        input  src_data, src_level,
        input  wr_ready,
        output desc_ready, src_read,
        output wr_valid, wr_addr, wr_count, wr_data, wr_last
    );

    modport slave (
        output desc_valid, desc_addr, desc_count,
        output src_data, src_level,
        output wr_ready,
        input  desc_ready, src_read,
        input  wr_valid, wr_addr, wr_count, wr_data, wr_last
    );
endinterface

// File: rtl/hififo_tpc_dma.sv
// To-PC DMA write engine: drains a FWFT FIFO into host memory as bursts split at 4 KiB.
// Optional partial-burst flush timer enabled by defining HIFIFO_TPC_FLUSH_EN.
module hififo_tpc_dma #(
    parameter int unsigned BURST_WORDS  = 16,
    parameter int unsigned COUNT_BITS   = 20,
    parameter int unsigned LEVEL_BITS   = 10,
    parameter int unsigned FLUSH_CYCLES = 256
) (
    input  logic             clock,
    input  logic             reset,
    hififo_tpc_dma_if.master bus,
    input  logic             abort,
    input  logic [31:0]      irq_match_val,
    input  logic             irq_match_arm,
    output logic [1:0]       irq,
    output logic [31:0]      words_sent
);

    localparam int unsigned PAGE_WORDS = 512;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REQ, S_DATA} state_t;

    state_t                state, state_n;
    logic [60:0]           addr, addr_n, addr_end;
    logic [COUNT_BITS-1:0] remaining, remaining_n, rem_end;
    logic [5:0]            len, len_n;
    logic [5:0]            beat, beat_n;
    logic                  abort_pend, abort_pend_n;
    logic                  done_n;
    logic                  level_ok;
    logic                  flush_fire;
    logic                  match_fire;
    logic                  armed;
    logic [31:0]           match_val;

    logic                  desc_ready_q;
    logic                  wr_valid_q;
    logic [63:0]           wr_addr_q;
    logic [5:0]            wr_count_q;
    logic                  src_read_q;
    logic                  wr_last_q;
    logic [1:0]            irq_q;
    logic [31:0]           words_sent_q;

    // Burst length limited by max burst, words left and distance to the next 4 KiB page.
    function automatic logic [5:0] calc_len(input logic [8:0] offset,
                                            input logic [COUNT_BITS-1:0] count);
        int unsigned room;
        int unsigned len_w;
        room  = PAGE_WORDS - 32'(offset);
        len_w = BURST_WORDS;
        if (32'(count) < len_w) len_w = 32'(count);
        if (room < len_w) len_w = room;
        return 6'(len_w);
    endfunction

    assign addr_end = addr + 61'(len);
    assign rem_end  = remaining - COUNT_BITS'(len);
    assign level_ok = 32'(bus.src_level) >= 32'(len);

`ifdef HIFIFO_TPC_FLUSH_EN
    logic [15:0] flush_timer;
    logic        partial;

    // Counts cycles spent waiting on a non-empty FIFO that cannot fill a full burst.
    assign partial    = (state == S_WAIT) && (bus.src_level != '0) && !level_ok;
    assign flush_fire = partial && (flush_timer == 16'(FLUSH_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset || !partial || flush_fire) flush_timer <= '0;
        else                                 flush_timer <= flush_timer + 16'd1;
    end
`else
    logic unused_flush_cycles;
    assign flush_fire          = 1'b0;
    assign unused_flush_cycles = (FLUSH_CYCLES == 32'd0);
`endif

    always_comb begin
        state_n      = state;
        addr_n       = addr;
        remaining_n  = remaining;
        len_n        = len;
        beat_n       = beat;
        abort_pend_n = abort_pend;
        done_n       = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.desc_valid && desc_ready_q) begin
                    if (bus.desc_count != '0) begin
                        addr_n      = bus.desc_addr;
                        remaining_n = bus.desc_count;
                        len_n       = calc_len(bus.desc_addr[8:0], bus.desc_count);
                        state_n     = S_WAIT;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (abort) begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                end else if (level_ok) begin
                    state_n = S_REQ;
                end else if (flush_fire) begin
                    len_n   = 6'(bus.src_level);
                    state_n = S_REQ;
                end
            end
            S_REQ: begin
                if (abort) abort_pend_n = 1'b1;
                if (bus.wr_ready) begin
                    state_n = S_DATA;
                    beat_n  = '0;
                end
            end
            S_DATA: begin
                if (abort) abort_pend_n = 1'b1;
                // A started burst always runs to completion; abort is honoured afterwards.
                if (beat == len - 6'd1) begin
                    addr_n      = addr_end;
                    remaining_n = rem_end;
                    if (rem_end == '0 || abort_pend || abort) begin
                        state_n      = S_IDLE;
                        done_n       = 1'b1;
                        abort_pend_n = 1'b0;
                    end else begin
                        state_n = S_WAIT;
                        len_n   = calc_len(addr_end[8:0], rem_end);
                    end
                end else begin
                    beat_n = beat + 6'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State and registered outputs derived from the next-state decision.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            addr         <= '0;
            remaining    <= '0;
            len          <= '0;
            beat         <= '0;
            abort_pend   <= 1'b0;
            desc_ready_q <= 1'b0;
            wr_valid_q   <= 1'b0;
            wr_addr_q    <= '0;
            wr_count_q   <= '0;
            src_read_q   <= 1'b0;
            wr_last_q    <= 1'b0;
            irq_q        <= '0;
            words_sent_q <= '0;
        end else begin
            state        <= state_n;
            addr         <= addr_n;
            remaining    <= remaining_n;
            len          <= len_n;
            beat         <= beat_n;
            abort_pend   <= abort_pend_n;
            desc_ready_q <= (state_n == S_IDLE);
            wr_valid_q   <= (state_n == S_REQ);
            if (state_n == S_REQ) begin
                wr_addr_q  <= {addr_n, 3'b000};
                wr_count_q <= len_n;
            end
            src_read_q   <= (state_n == S_DATA);
            wr_last_q    <= (state_n == S_DATA) && (beat_n == len_n - 6'd1);
            irq_q        <= {done_n, match_fire};
            words_sent_q <= words_sent_q + 32'(src_read_q);
        end
    end

    // A new arm takes priority and is compared against the value it brings.
    assign match_fire = irq_match_arm ? (words_sent_q == irq_match_val)
                                      : (armed && (words_sent_q == match_val));

    always_ff @(posedge clock) begin
        if (reset) begin
            armed     <= 1'b0;
            match_val <= '0;
        end else if (irq_match_arm) begin
            armed     <= (words_sent_q != irq_match_val);
            match_val <= irq_match_val;
        end else if (match_fire) begin
            armed <= 1'b0;
        end
    end

    assign bus.desc_ready = desc_ready_q;
    assign bus.wr_valid   = wr_valid_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_count   = wr_count_q;
    assign bus.src_read   = src_read_q;
    assign bus.wr_last    = wr_last_q;
    assign bus.wr_data    = bus.src_data;
    assign irq            = irq_q;
    assign words_sent     = words_sent_q;

endmodule

// File: tb/tb_hififo_tpc_dma.sv
// Bench for hififo_tpc_dma: directed descriptors, burst/data/interrupt model checked every cycle.
// Flush expectations follow HIFIFO_TPC_FLUSH_EN the same way as the design.
module tb_hififo_tpc_dma;
    localparam int unsigned COUNT_BITS = 20;
    localparam int unsigned LEVEL_BITS = 10;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        abort = 1'b0;
    logic [31:0] irq_match_val = '0;
    logic        irq_match_arm = 1'b0;
    logic [1:0]  irq;
    logic [31:0] words_sent;

    hififo_tpc_dma_if #(.COUNT_BITS(COUNT_BITS), .LEVEL_BITS(LEVEL_BITS)) bus ();

    hififo_tpc_dma #(
        .BURST_WORDS(16), .COUNT_BITS(COUNT_BITS), .LEVEL_BITS(LEVEL_BITS), .FLUSH_CYCLES(256)
    ) dut (
        .clock(clock), .reset(reset), .bus(bus), .abort(abort),
        .irq_match_val(irq_match_val), .irq_match_arm(irq_match_arm),
        .irq(irq), .words_sent(words_sent)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Source FIFO: word n of the stream carries a recognisable pattern.
    function automatic logic [63:0] pattern(input int unsigned n);
        return {~n, n ^ 32'h5A5A_0000};
    endfunction

    int unsigned wr_ptr = 0;
    int unsigned rd_ptr = 0;
    assign bus.src_data  = pattern(rd_ptr);
    assign bus.src_level = LEVEL_BITS'(wr_ptr - rd_ptr);
    always @(posedge clock) if (bus.src_read) rd_ptr <= rd_ptr + 1;

    typedef struct { logic [63:0] a; logic [5:0] c; } burst_t;
    burst_t expq[$];

    // Monitor / model state
    int          cyc = 0;
    logic        prev_reset = 1'b0;
    logic        prev_wv = 1'b0, prev_wr = 1'b0;
    logic [63:0] prev_addr = '0;
    logic [5:0]  prev_cnt = '0;
    logic        in_burst = 1'b0;
    int          beat = 0, cur_cnt = 0;
    logic [31:0] ws_m = '0;
    logic        armed_m = 1'b0;
    logic [31:0] val_m = '0;
    logic        exp_irq0 = 1'b0;
    int          hs_seen = 0, irq0_seen = 0, irq1_seen = 0;
    int          ws32_cyc = -1, irq0_cyc = -1;

    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            if (prev_reset)
                check("reset_zero", 64'({bus.desc_ready, bus.src_read, bus.wr_valid, bus.wr_last,
                      irq, words_sent, bus.wr_count} == '0) & 64'(bus.wr_addr == '0), 64'd1);
            prev_reset = 1'b1;
            expq.delete();
            in_burst = 1'b0; ws_m = '0; armed_m = 1'b0; exp_irq0 = 1'b0;
            prev_wv = 1'b0; prev_wr = 1'b0;
        end else begin
            prev_reset = 1'b0;
            check("words_sent", 64'(words_sent), 64'(ws_m));
            check("irq0", 64'(irq[0]), 64'(exp_irq0));
            if (irq[0]) begin irq0_seen++; irq0_cyc = cyc; end
            if (irq[1]) irq1_seen++;
            if (words_sent == 32'd32 && ws32_cyc < 0) ws32_cyc = cyc;
            // match rule: new arm wins and is compared with the current count
            if (irq_match_arm) begin
                exp_irq0 = (ws_m == irq_match_val);
                armed_m  = !exp_irq0;
                val_m    = irq_match_val;
            end else if (armed_m && ws_m == val_m) begin
                exp_irq0 = 1'b1;
                armed_m  = 1'b0;
            end else begin
                exp_irq0 = 1'b0;
            end
            if (prev_wv && !prev_wr) begin
                check("req_hold_valid", 64'(bus.wr_valid), 64'd1);
                check("req_hold_addr", bus.wr_addr, prev_addr);
                check("req_hold_count", 64'(bus.wr_count), 64'(prev_cnt));
            end
            if (in_burst) begin
                check("burst_read", 64'(bus.src_read), 64'd1);
                if (bus.src_read) begin
                    check("wr_last", 64'(bus.wr_last), 64'(beat == cur_cnt - 1));
                    check("wr_data", bus.wr_data, pattern(rd_ptr));
                    check("src_nonempty", 64'(bus.src_level != '0), 64'd1);
                    beat++;
                    if (beat == cur_cnt) in_burst = 1'b0;
                end
            end else begin
                check("idle_read", 64'({bus.src_read, bus.wr_last}), 64'd0);
            end
            if (bus.wr_valid && bus.wr_ready) begin
                hs_seen++;
                check("req_expected", 64'(expq.size() != 0), 64'd1);
                if (expq.size() != 0) begin
                    check("req_addr", bus.wr_addr, expq[0].a);
                    check("req_count", 64'(bus.wr_count), 64'(expq[0].c));
                    void'(expq.pop_front());
                end
                in_burst = 1'b1; beat = 0; cur_cnt = int'(bus.wr_count);
            end
            if (bus.src_read) ws_m = ws_m + 32'd1;
            prev_wv = bus.wr_valid; prev_wr = bus.wr_ready;
            prev_addr = bus.wr_addr; prev_cnt = bus.wr_count;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push(input int unsigned n);
        wr_ptr = wr_ptr + n;
    endtask

    task automatic expect_burst(input logic [63:0] a, input logic [5:0] c);
        burst_t b;
        b.a = a; b.c = c;
        expq.push_back(b);
    endtask

    task automatic send_desc(input logic [60:0] a, input logic [19:0] c);
        int k = 0;
        bus.desc_addr = a; bus.desc_count = c; bus.desc_valid = 1'b1;
        do begin @(negedge clock); k++; end while (!bus.desc_ready && k < 500);
        check("desc_accept", 64'(bus.desc_ready), 64'd1);
        @(posedge clock); #1;
        bus.desc_valid = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int k = 0;
        do begin @(negedge clock); k++; end while (!bus.desc_ready && k < maxc);
        check("idle_reached", 64'(bus.desc_ready), 64'd1);
        tick(1);
    endtask

    task automatic wait_read(input int maxc);
        int k = 0;
        do begin @(negedge clock); k++; end while (!bus.src_read && k < maxc);
        check("read_reached", 64'(bus.src_read), 64'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time %0t exceeded limit 1000000", $time);
        $fatal(1);
    end

    initial begin
        int i1, i0, hs0;
        bus.desc_valid = 1'b0; bus.desc_addr = '0; bus.desc_count = '0; bus.wr_ready = 1'b1;
        tick(3);
        reset = 1'b0;
        @(negedge clock);
        check("ready_after_reset", 64'(bus.desc_ready), 64'd0);
        @(negedge clock);
        check("idle_ready", 64'(bus.desc_ready), 64'd1);
        tick(1);

        // T1: 64 words from 0x1000
        i1 = irq1_seen;
        push(64);
        expect_burst(64'h8000, 6'd16); expect_burst(64'h8080, 6'd16);
        expect_burst(64'h8100, 6'd16); expect_burst(64'h8180, 6'd16);
        send_desc(61'h1000, 20'd64);
        wait_idle(2000);
        check("t1_left", 64'(expq.size()), 64'd0);
        check("t1_words", 64'(words_sent), 64'd64);
        check("t1_reads", 64'(rd_ptr), 64'd64);
        check("t1_done", 64'(irq1_seen - i1), 64'd1);

        // zero-count descriptor: done pulse, no transfer
        i1 = irq1_seen; hs0 = hs_seen;
        send_desc(61'h1234, 20'd0);
        tick(2);
        check("zero_done", 64'(irq1_seen - i1), 64'd1);
        check("zero_noreq", 64'(hs_seen - hs0), 64'd0);
        check("zero_ready", 64'(bus.desc_ready), 64'd1);

        // T2: page-boundary split
        push(40);
        expect_burst(64'hF80, 6'd16); expect_burst(64'h1000, 6'd16); expect_burst(64'h1080, 6'd8);
        send_desc(61'h1F0, 20'd40);
        wait_idle(2000);
        check("t2_left", 64'(expq.size()), 64'd0);
        check("t2_words", 64'(words_sent), 64'd104);

        // T3: 20 words with only 5 available
        hs0 = hs_seen;
        push(5);
`ifdef HIFIFO_TPC_FLUSH_EN
        expect_burst(64'h10000, 6'd5);
        send_desc(61'h2000, 20'd20);
        tick(240);
        check("flush_early", 64'(hs_seen - hs0), 64'd0);
        tick(60);
        check("flush_burst", 64'(hs_seen - hs0), 64'd1);
        expect_burst(64'h10028, 6'd15);
`else
        send_desc(61'h2000, 20'd20);
        tick(400);
        check("no_partial", 64'(hs_seen - hs0), 64'd0);
        expect_burst(64'h10000, 6'd16); expect_burst(64'h10080, 6'd4);
`endif
        push(15);
        wait_idle(2000);
        check("t3_left", 64'(expq.size()), 64'd0);
        check("t3_words", 64'(words_sent), 64'd124);

        // T4: request back-pressure
        bus.wr_ready = 1'b0;
        push(16);
        expect_burst(64'h18000, 6'd16);
        send_desc(61'h3000, 20'd16);
        begin
            int k = 0;
            do begin @(negedge clock); k++; end while (!bus.wr_valid && k < 100);
        end
        check("t4_req", 64'(bus.wr_valid), 64'd1);
        repeat (50) @(negedge clock);
        check("t4_no_read", 64'(rd_ptr), 64'd124);
        tick(1);
        bus.wr_ready = 1'b1;
        wait_idle(200);
        check("t4_reads", 64'(rd_ptr), 64'd140);

        // T5: abort on the 3rd data cycle
        i1 = irq1_seen;
        push(64);
        expect_burst(64'h20000, 6'd16);
        send_desc(61'h4000, 20'd64);
        wait_read(200);
        @(negedge clock); @(negedge clock);
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        wait_idle(200);
        hs0 = hs_seen;
        check("t5_done", 64'(irq1_seen - i1), 64'd1);
        check("t5_reads", 64'(rd_ptr), 64'd156);
        tick(30);
        check("t5_noreq", 64'(hs_seen - hs0), 64'd0);
        check("t5_ready", 64'(bus.desc_ready), 64'd1);
        check("t5_left", 64'(expq.size()), 64'd0);

        // T6: match interrupt after reset, using the 48 words left in the FIFO
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
        ws32_cyc = -1; irq0_cyc = -1; i0 = irq0_seen;
        irq_match_val = 32'd32; irq_match_arm = 1'b1;
        tick(1);
        irq_match_arm = 1'b0;
        expect_burst(64'h28000, 6'd16); expect_burst(64'h28080, 6'd16); expect_burst(64'h28100, 6'd16);
        send_desc(61'h5000, 20'd48);
        wait_idle(2000);
        tick(3);
        check("t6_irq0_count", 64'(irq0_seen - i0), 64'd1);
        check("t6_irq0_delay", 64'(irq0_cyc - ws32_cyc), 64'd1);
        check("t6_words", 64'(words_sent), 64'd48);

        // T7: reset in the middle of a burst
        push(16);
        expect_burst(64'h30000, 6'd16);
        send_desc(61'h6000, 20'd16);
        wait_read(200);
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock); @(negedge clock);
        check("t7_src_read", 64'(bus.src_read), 64'd0);
        check("t7_wr_last", 64'(bus.wr_last), 64'd0);
        check("t7_wr_valid", 64'(bus.wr_valid), 64'd0);
        check("t7_words", 64'(words_sent), 64'd0);
        check("t7_wr_addr", bus.wr_addr, 64'd0);
        tick(1);
        reset = 1'b0;
        tick(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
